// File: rtl/lsu_mem_pkg.sv
// Shared widths, RV32I load/store funct3 codes and LSU FSM states.
package lsu_mem_pkg;

  localparam int unsigned DATA_WIDTH = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    LSU_IDLE   = 3'd0,
    LSU_LOAD   = 3'd1,
    LSU_STORE  = 3'd2,
    LSU_RMW_RD = 3'd3,
    LSU_RMW_WR = 3'd4,
    LSU_RESP   = 3'd5
  } lsu_state_e;

endpackage

// File: rtl/lsu_mem_align.sv
// Little-endian lane handling: load extract/extend and sub-word store merge.
module lsu_align
  import lsu_mem_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] ld_word,
  input  logic [DATA_WIDTH-1:0] st_old,
  input  logic [DATA_WIDTH-1:0] st_wdata,
  input  logic [1:0]            addr_lo,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] ld_rdata,
  output logic [DATA_WIDTH-1:0] st_word
);

  logic [4:0]            byte_sh;
  logic [4:0]            half_sh;
  logic [DATA_WIDTH-1:0] byte_w;
  logic [DATA_WIDTH-1:0] half_w;
  logic [DATA_WIDTH-1:0] mask;
  logic [DATA_WIDTH-1:0] ins;

  always_comb begin
    byte_sh = {addr_lo, 3'b000};
    half_sh = {addr_lo[1], 4'b0000};
    byte_w  = ld_word >> byte_sh;
    half_w  = ld_word >> half_sh;
    case (funct3)
      F3_B:    ld_rdata = {{24{byte_w[7]}}, byte_w[7:0]};
      F3_BU:   ld_rdata = {24'h0, byte_w[7:0]};
      F3_H:    ld_rdata = {{16{half_w[15]}}, half_w[15:0]};
      F3_HU:   ld_rdata = {16'h0, half_w[15:0]};
      default: ld_rdata = ld_word;
    endcase
  end

  // Sub-word stores: shift a lane mask and the right-aligned data into place.
  always_comb begin
    case (funct3)
      F3_B: begin
        mask = 32'h0000_00ff << byte_sh;
        ins  = {24'h0, st_wdata[7:0]} << byte_sh;
      end
      F3_H: begin
        mask = 32'h0000_ffff << half_sh;
        ins  = {16'h0, st_wdata[15:0]} << half_sh;
      end
      default: begin
        mask = '1;
        ins  = st_wdata;
      end
    endcase
    st_word = (st_old & ~mask) | (ins & mask);
  end

endmodule

// File: rtl/lsu_mem.sv
// Load/store unit FSM: request capture, access checks, RAM sequencing incl. RMW.
module lsu_mem
  import lsu_mem_pkg::*;
#(
  parameter int unsigned MEM_WORDS = 65
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [DATA_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_data_in,
  output logic                  mem_write_en,
  output logic                  mem_read_en,
  input  logic [DATA_WIDTH-1:0] mem_data_out
);

  lsu_state_e            state_q, state_d;
  logic                  we_q, we_d;
  logic [2:0]            f3_q, f3_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [DATA_WIDTH-1:0] old_q, old_d;
  logic                  err_q, err_d;

  logic                  misal, oor, illegal, req_err;
  logic [DATA_WIDTH-1:0] word_idx;
  logic [DATA_WIDTH-1:0] ld_rdata, st_word;

  assign word_idx = {2'b00, addr_q[DATA_WIDTH-1:2]};

  // The check is evaluated on the request as it is captured so errors can
  // go straight to RESP on the accept edge.
  always_comb begin
    misal   = ((req_funct3 == F3_H || req_funct3 == F3_HU) && req_addr[0]) ||
              (req_funct3 == F3_W && req_addr[1:0] != 2'b00);
    oor     = {2'b00, req_addr[DATA_WIDTH-1:2]} >= DATA_WIDTH'(MEM_WORDS);
    illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
              (req_funct3 == 3'b111) ||
              (req_we && (req_funct3 == F3_BU || req_funct3 == F3_HU));
    req_err = misal | oor | illegal;
  end

  lsu_align u_align (
    .ld_word  (mem_data_out),
    .st_old   (old_q),
    .st_wdata (wdata_q),
    .addr_lo  (addr_q[1:0]),
    .funct3   (f3_q),
    .ld_rdata (ld_rdata),
    .st_word  (st_word)
  );

  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    f3_d         = f3_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    old_d        = old_q;
    err_d        = err_q;
    req_ready    = 1'b0;
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    resp_err     = 1'b0;
    mem_address  = '0;
    mem_data_in  = '0;
    mem_write_en = 1'b0;
    mem_read_en  = 1'b0;
    case (state_q)
      LSU_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          we_d    = req_we;
          f3_d    = req_funct3;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          err_d   = req_err;
          rdata_d = '0;
          if (req_err)               state_d = LSU_RESP;
          else if (!req_we)          state_d = LSU_LOAD;
          else if (req_funct3 == F3_W) state_d = LSU_STORE;
          else                       state_d = LSU_RMW_RD;
        end
      end
      LSU_LOAD: begin
        mem_address = word_idx;
        mem_read_en = 1'b1;
        rdata_d     = ld_rdata;
        state_d     = LSU_RESP;
      end
      LSU_STORE: begin
        mem_address  = word_idx;
        mem_data_in  = wdata_q;
        mem_write_en = ~rst;
        state_d      = LSU_RESP;
      end
      LSU_RMW_RD: begin
        mem_address = word_idx;
        mem_read_en = 1'b1;
        old_d       = mem_data_out;
        state_d     = LSU_RMW_WR;
      end
      LSU_RMW_WR: begin
        mem_address  = word_idx;
        mem_data_in  = st_word;
        mem_write_en = ~rst;
        state_d      = LSU_RESP;
      end
      LSU_RESP: begin
        resp_valid = 1'b1;
        resp_rdata = rdata_q;
        resp_err   = err_q;
        state_d    = LSU_IDLE;
      end
      default: state_d = LSU_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LSU_IDLE;
      we_q    <= 1'b0;
      f3_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      old_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      old_q   <= old_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem with a behavioural 65-word asynchronous-read RAM.
module tb_lsu_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_address, mem_data_in, mem_data_out;
  logic        mem_write_en, mem_read_en;
  logic        ram_clr;
  logic [31:0] ram [0:64];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lsu_mem #(.MEM_WORDS(65)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_we       (req_we),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_address  (mem_address),
    .mem_data_in  (mem_data_in),
    .mem_write_en (mem_write_en),
    .mem_read_en  (mem_read_en),
    .mem_data_out (mem_data_out)
  );

  assign mem_data_out = (mem_address < 32'd65) ? ram[mem_address[6:0]] : 32'h0;

  always @(posedge clk) begin
    if (ram_clr) begin
      for (int i = 0; i < 65; i++) ram[i] <= 32'h0;
    end else if (mem_write_en && mem_address < 32'd65) begin
      ram[mem_address[6:0]] <= mem_data_in;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] rdata;
    logic        err;
    int          wr;
    int          rd;
  } vec_t;

  localparam int NV = 18;
  vec_t v [NV];

  task automatic run_vec(input vec_t t, input string name);
    int  lat, wr, rd;
    bit  got;
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = t.we;
    req_funct3 = t.f3;
    req_addr   = t.addr;
    req_wdata  = t.wdata;
    chk({name, " ready"}, 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'hFFFF_FFFF;
    req_wdata = 32'h5A5A_5A5A;
    lat = 0; wr = 0; rd = 0; got = 0;
    for (int c = 1; c <= 8 && !got; c++) begin
      @(negedge clk);
      if (mem_write_en) wr++;
      if (mem_read_en) rd++;
      if (resp_valid) begin
        got = 1;
        lat = c;
        chk({name, " rdata"}, resp_rdata, t.rdata);
        chk({name, " err"}, 32'(resp_err), 32'(t.err));
      end
    end
    chk({name, " resp seen"}, 32'(got), 32'd1);
    chk({name, " latency"}, 32'(lat), 32'(t.lat));
    chk({name, " write pulses"}, 32'(wr), 32'(t.wr));
    chk({name, " read pulses"}, 32'(rd), 32'(t.rd));
  endtask

  initial begin
    v[0]  = '{1'b1, 3'b010, 32'h24,  32'hDEADBEEF, 2, 32'h0,        1'b0, 1, 0};
    v[1]  = '{1'b0, 3'b010, 32'h24,  32'h0,        2, 32'hDEADBEEF, 1'b0, 0, 1};
    v[2]  = '{1'b0, 3'b000, 32'h24,  32'h0,        2, 32'hFFFFFFEF, 1'b0, 0, 1};
    v[3]  = '{1'b0, 3'b100, 32'h25,  32'h0,        2, 32'h000000BE, 1'b0, 0, 1};
    v[4]  = '{1'b0, 3'b001, 32'h26,  32'h0,        2, 32'hFFFFDEAD, 1'b0, 0, 1};
    v[5]  = '{1'b0, 3'b101, 32'h26,  32'h0,        2, 32'h0000DEAD, 1'b0, 0, 1};
    v[6]  = '{1'b1, 3'b000, 32'h17,  32'hFFFFFF12, 3, 32'h0,        1'b0, 1, 1};
    v[7]  = '{1'b1, 3'b001, 32'h14,  32'h7777ABCD, 3, 32'h0,        1'b0, 1, 1};
    v[8]  = '{1'b0, 3'b010, 32'h14,  32'h0,        2, 32'h1200ABCD, 1'b0, 0, 1};
    v[9]  = '{1'b0, 3'b010, 32'h26,  32'h0,        1, 32'h0,        1'b1, 0, 0};
    v[10] = '{1'b1, 3'b010, 32'h104, 32'h11111111, 1, 32'h0,        1'b1, 0, 0};
    v[11] = '{1'b1, 3'b100, 32'h14,  32'hFFFFFFFF, 1, 32'h0,        1'b1, 0, 0};
    v[12] = '{1'b0, 3'b011, 32'h14,  32'h0,        1, 32'h0,        1'b1, 0, 0};
    v[13] = '{1'b0, 3'b001, 32'h25,  32'h0,        1, 32'h0,        1'b1, 0, 0};
    v[14] = '{1'b1, 3'b000, 32'h103, 32'h00000080, 3, 32'h0,        1'b0, 1, 1};
    v[15] = '{1'b0, 3'b000, 32'h103, 32'h0,        2, 32'hFFFFFF80, 1'b0, 0, 1};
    v[16] = '{1'b0, 3'b010, 32'h14,  32'h0,        2, 32'h1200ABCD, 1'b0, 0, 1};
    v[17] = '{1'b0, 3'b101, 32'h16,  32'h0,        2, 32'h00001200, 1'b0, 0, 1};

    rst = 1'b1; ram_clr = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = 32'h0; req_wdata = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; ram_clr = 1'b0;
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_err", 32'(resp_err), 32'd0);
    chk("reset resp_rdata", resp_rdata, 32'h0);
    chk("reset mem_we", 32'(mem_write_en), 32'd0);
    chk("reset mem_re", 32'(mem_read_en), 32'd0);
    chk("reset mem_address", mem_address, 32'h0);
    chk("reset mem_data_in", mem_data_in, 32'h0);

    for (int i = 0; i < NV; i++) run_vec(v[i], $sformatf("vec%0d", i));

    @(negedge clk);
    chk("ram word 9", ram[9], 32'hDEADBEEF);
    chk("ram word 5", ram[5], 32'h1200ABCD);
    chk("ram word 64", ram[64], 32'h80000000);

    // Reset during RMW_WR of SB @ 0x14 must not write.
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
    req_addr = 32'h14; req_wdata = 32'h00000077;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_rd read_en", 32'(mem_read_en), 32'd1);
    @(negedge clk);
    chk("rmw_wr write_en", 32'(mem_write_en), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst gates write_en", 32'(mem_write_en), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post-rst req_ready", 32'(req_ready), 32'd1);
    chk("post-rst resp_valid", 32'(resp_valid), 32'd0);
    begin
      int rv = 0;
      repeat (3) begin
        @(negedge clk);
        if (resp_valid) rv++;
      end
      chk("no resp after abort", 32'(rv), 32'd0);
    end
    chk("ram word 5 after abort", ram[5], 32'h1200ABCD);

    // req_valid held high across two loads.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h24;
    @(posedge clk);
    #1 req_addr = 32'h14;
    @(negedge clk);
    chk("b2b c1 ready", 32'(req_ready), 32'd0);
    chk("b2b c1 resp", 32'(resp_valid), 32'd0);
    @(negedge clk);
    chk("b2b c2 ready", 32'(req_ready), 32'd0);
    chk("b2b c2 resp", 32'(resp_valid), 32'd1);
    chk("b2b c2 rdata", resp_rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("b2b c3 ready", 32'(req_ready), 32'd1);
    chk("b2b c3 resp", 32'(resp_valid), 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("b2b c4 ready", 32'(req_ready), 32'd0);
    chk("b2b c4 read_en", 32'(mem_read_en), 32'd1);
    @(negedge clk);
    chk("b2b c5 resp", 32'(resp_valid), 32'd1);
    chk("b2b c5 rdata", resp_rdata, 32'h1200ABCD);
    @(negedge clk);
    chk("b2b idle rdata", resp_rdata, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
